// File: rtl/spi_bridge.sv
// spi_bridge: SPI mode-0 slave front-end (MSB first) for the instruction decoder.
// SCLK, CS_N and MOSI are oversampled on clk. Received bytes are delivered
// on data_in with a one-cycle byte_sync strobe. The decoder's data_out reply
// is shifted out on MISO during the following byte.
//
// Ports:
//   clk, rst_n          system clock, asynchronous active-low reset
//   sclk, cs_n, mosi    SPI pins, asynchronous to clk
//   miso, miso_oe       serial data out and its pad output enable
//   byte_sync, data_in  new-byte strobe and last received byte
//   data_out            reply byte, sampled one clk after byte_sync
//   frame_start/_end    one-clk pulses on synchronised CS falling/rising edge
module spi_bridge #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [7:0]  IDLE_TX     = 8'h00
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sclk,
    input  logic       cs_n,
    input  logic       mosi,
    output logic       miso,
    output logic       miso_oe,
    output logic       byte_sync,
    output logic [7:0] data_in,
    input  logic [7:0] data_out,
    output logic       frame_start,
    output logic       frame_end
);

    localparam int unsigned    FW        = $clog2(SYNC_STAGES + 1);
    localparam logic [FW-1:0]  FLUSH_MAX = FW'(SYNC_STAGES);

    typedef enum logic [1:0] {
        ST_LOCKOUT,
        ST_IDLE,
        ST_FRAME
    } state_t;

    state_t state, state_nx;

    logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
    logic                   sclk_s, cs_s, mosi_s;
    logic                   sclk_d, cs_d;
    logic [FW-1:0]          flush_cnt;
    logic                   flush_done;
    logic                   cs_fall, cs_rise, active;
    logic                   sclk_rise, sclk_fall;
    logic [2:0]             bit_cnt;
    logic [7:0]             rx_shift, tx_shift;
    logic                   load_q;

    // ---------------------------------------------------------------
    // Input synchronisers plus one edge-detect register on sclk/cs
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync <= '0;
            cs_sync   <= '1;
            mosi_sync <= '0;
            sclk_d    <= 1'b0;
            cs_d      <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
            sclk_d    <= sclk_s;
            cs_d      <= cs_s;
        end
    end

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign cs_s      = cs_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_d;
    assign sclk_fall = ~sclk_s & sclk_d;

    // Counts cycles after reset until the synchronisers hold real samples,
    // so a CS already low at reset release is not mistaken for a frame start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flush_cnt <= '0;
        end else if (!flush_done) begin
            flush_cnt <= flush_cnt + 1'b1;
        end
    end

    assign flush_done = (flush_cnt == FLUSH_MAX);

    // ---------------------------------------------------------------
    // Frame FSM
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_LOCKOUT;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cs_fall  = 1'b0;
        cs_rise  = 1'b0;
        active   = 1'b0;
        case (state)
            ST_LOCKOUT: begin
                // Only leave lockout once CS is seen deasserted.
                if (flush_done && cs_s) begin
                    state_nx = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (cs_d && !cs_s) begin
                    cs_fall  = 1'b1;
                    state_nx = ST_FRAME;
                end
            end
            ST_FRAME: begin
                active = ~cs_s;
                if (!cs_d && cs_s) begin
                    cs_rise  = 1'b1;
                    state_nx = ST_IDLE;
                end
            end
            default: state_nx = ST_LOCKOUT;
        endcase
    end

    // ---------------------------------------------------------------
    // Receive / transmit datapath
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt     <= '0;
            rx_shift    <= '0;
            tx_shift    <= IDLE_TX;
            data_in     <= '0;
            byte_sync   <= 1'b0;
            load_q      <= 1'b0;
            miso_oe     <= 1'b0;
            frame_start <= 1'b0;
            frame_end   <= 1'b0;
        end else begin
            byte_sync   <= 1'b0;
            frame_start <= cs_fall;
            frame_end   <= cs_rise;
            load_q      <= byte_sync;

            if (cs_fall) begin
                bit_cnt  <= '0;
                rx_shift <= '0;
                miso_oe  <= 1'b1;
            end else if (cs_rise) begin
                bit_cnt  <= '0;
                miso_oe  <= 1'b0;
            end else if (active && sclk_rise) begin
                rx_shift <= {rx_shift[6:0], mosi_s};
                bit_cnt  <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                    byte_sync <= 1'b1;
                    data_in   <= {rx_shift[6:0], mosi_s};
                end
            end

            // Reply load has priority over a shift; no shift at bit_cnt 0
            // keeps the first bit of each byte on MISO for its rising edge.
            if (cs_fall) begin
                tx_shift <= IDLE_TX;
            end else if (load_q) begin
                tx_shift <= data_out;
            end else if (active && sclk_fall && (bit_cnt != 3'd0)) begin
                tx_shift <= {tx_shift[6:0], 1'b0};
            end
        end
    end

    assign miso = (state == ST_FRAME && !cs_s) ? tx_shift[7] : 1'b0;

endmodule

// File: tb/tb_spi_bridge.sv
// tb_spi_bridge: randomized self-checking bench for spi_bridge.
// A behavioural SPI master drives frames; a decoder model answers each
// received byte with a reply that must appear on MISO during the next byte.
module tb_spi_bridge;

    localparam int unsigned SYNC_STAGES = 2;
    localparam logic [7:0]  IDLE_TX     = 8'h00;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       sclk = 1'b0;
    logic       cs_n = 1'b1;
    logic       mosi = 1'b0;
    logic [7:0] data_out = 8'h00;
    logic       miso, miso_oe, byte_sync, frame_start, frame_end;
    logic [7:0] data_in;

    spi_bridge #(
        .SYNC_STAGES(SYNC_STAGES),
        .IDLE_TX    (IDLE_TX)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sclk       (sclk),
        .cs_n       (cs_n),
        .mosi       (mosi),
        .miso       (miso),
        .miso_oe    (miso_oe),
        .byte_sync  (byte_sync),
        .data_in    (data_in),
        .data_out   (data_out),
        .frame_start(frame_start),
        .frame_end  (frame_end)
    );

    always #5 clk = ~clk;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    // Reference model state
    logic [7:0] exp_q[$];     // bytes the master completed, awaiting byte_sync
    logic [7:0] resp_q[$];    // planned decoder replies
    logic [7:0] last_resp = 8'h00;
    logic [7:0] fb[8];        // bytes of the next frame
    int         fs_cnt = 0;
    int         fe_cnt = 0;
    int         bs_cnt = 0;
    longint     t_rise8 = 0;
    int         half = 4;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Master: nbits of b, MSB first; MISO captured at each raw rising edge.
    task automatic send_bits(input logic [7:0] b, input int nbits, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            mosi = b[7-i];
            tick(half);
            sclk = 1'b1;
            rx = {rx[6:0], miso};
            if (i == 7) t_rise8 = $time;
            tick(half);
            sclk = 1'b0;
        end
    endtask

    task automatic wait_sync(input int target);
        int t = 0;
        while (bs_cnt < target && t < 60) begin
            tick(1);
            t++;
        end
        check_eq("sync_timeout", bs_cnt >= target, 1'b1);
    endtask

    task automatic do_frame(input int n);
        int fs0 = fs_cnt;
        int fe0 = fe_cnt;
        int bs0 = bs_cnt;
        logic [7:0] rx, exp_miso;
        cs_n = 1'b0;
        tick(SYNC_STAGES + 4);
        check_eq("frame_start", fs_cnt, fs0 + 1);
        check_eq("miso_oe_on", miso_oe, 1'b1);
        for (int k = 0; k < n; k++) begin
            exp_miso = (k == 0) ? IDLE_TX : last_resp;
            exp_q.push_back(fb[k]);
            send_bits(fb[k], 8, rx);
            check_eq("miso_byte", rx, exp_miso);
            wait_sync(bs0 + k + 1);
            tick(2);
        end
        tick(half);
        cs_n = 1'b1;
        tick(SYNC_STAGES + 4);
        check_eq("frame_end", fe_cnt, fe0 + 1);
        check_eq("miso_oe_off", miso_oe, 1'b0);
        check_eq("miso_idle", miso, 1'b0);
        check_eq("sync_count", bs_cnt, bs0 + n);
        check_eq("pending_bytes", exp_q.size(), 0);
    endtask

    // Monitor and decoder model
    initial begin
        longint lat;
        logic [7:0] resp;
        forever begin
            @(negedge clk);
            if (frame_start === 1'b1) fs_cnt++;
            if (frame_end === 1'b1) fe_cnt++;
            if (byte_sync === 1'b1) begin
                bs_cnt++;
                lat = ($time - t_rise8) / 10;
                check_eq("sync_latency",
                         (lat >= SYNC_STAGES + 1) && (lat <= SYNC_STAGES + 2), 1'b1);
                if (exp_q.size() == 0) check_eq("sync_unexpected", byte_sync, 1'b0);
                else check_eq("data_in", data_in, exp_q.pop_front());
                resp = (resp_q.size() != 0) ? resp_q.pop_front() : 8'($urandom);
                @(posedge clk);
                #1;
                data_out  = resp;
                last_resp = resp;
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        logic [7:0] rx;
        int fs0, fe0, bs0;

        // Reset with random pin activity
        #2 rst_n = 1'b0;
        for (int i = 0; i < 10; i++) begin
            sclk = 1'($urandom); cs_n = 1'($urandom); mosi = 1'($urandom);
            tick(1);
        end
        check_eq("rst_miso", miso, 1'b0);
        check_eq("rst_miso_oe", miso_oe, 1'b0);
        check_eq("rst_byte_sync", byte_sync, 1'b0);
        check_eq("rst_data_in", data_in, 8'h00);
        sclk = 1'b0; cs_n = 1'b1; mosi = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(10);
        check_eq("idle_miso_oe", miso_oe, 1'b0);
        check_eq("idle_frames", fs_cnt + fe_cnt + bs_cnt, 0);

        // Single byte
        half = SYNC_STAGES + 2;
        fb[0] = 8'hA5;
        do_frame(1);

        // Read transaction: command then dummy, reply 3C
        half = SYNC_STAGES + 3;
        resp_q.push_back(8'h3C);
        fb[0] = 8'h05; fb[1] = 8'($urandom);
        do_frame(2);

        // Back-to-back bytes
        fb[0] = 8'h81; fb[1] = 8'h7E;
        do_frame(2);

        // Aborted byte
        fs0 = fs_cnt; fe0 = fe_cnt; bs0 = bs_cnt;
        cs_n = 1'b0;
        tick(SYNC_STAGES + 4);
        send_bits(8'hFF, 5, rx);
        tick(half);
        cs_n = 1'b1;
        tick(SYNC_STAGES + 6);
        check_eq("abort_no_sync", bs_cnt, bs0);
        check_eq("abort_frame_end", fe_cnt, fe0 + 1);
        check_eq("abort_miso_oe", miso_oe, 1'b0);
        fb[0] = 8'h12;
        do_frame(1);

        // Reset mid-byte after 4 bits
        cs_n = 1'b0;
        tick(SYNC_STAGES + 4);
        send_bits(8'hF0, 4, rx);
        rst_n = 1'b0;
        tick(1);
        check_eq("midrst_miso_oe", miso_oe, 1'b0);
        check_eq("midrst_data_in", data_in, 8'h00);
        check_eq("midrst_miso", miso, 1'b0);
        cs_n = 1'b1; sclk = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(SYNC_STAGES + 6);
        fb[0] = 8'hC3;
        do_frame(1);

        // Reset released with CS already low: no frame until a fresh falling edge
        rst_n = 1'b0;
        cs_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(SYNC_STAGES + 6);
        fs0 = fs_cnt; fe0 = fe_cnt; bs0 = bs_cnt;
        send_bits(8'h5A, 8, rx);
        tick(10);
        check_eq("stale_cs_no_sync", bs_cnt, bs0);
        check_eq("stale_cs_no_start", fs_cnt, fs0);
        check_eq("stale_cs_miso_oe", miso_oe, 1'b0);
        check_eq("stale_cs_miso", rx, 8'h00);
        cs_n = 1'b1;
        tick(SYNC_STAGES + 6);
        check_eq("stale_cs_no_end", fe_cnt, fe0);

        // Random frames
        for (int f = 0; f < 20; f++) begin
            int nb;
            half = $urandom_range(SYNC_STAGES + 5, SYNC_STAGES + 2);
            nb = $urandom_range(4, 1);
            for (int k = 0; k < nb; k++) fb[k] = 8'($urandom);
            do_frame(nb);
            tick($urandom_range(6, 1));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
